// File: rtl/cpu_pkg.sv
// Shared definitions for the CR16-style multi-cycle control unit:
// FSM states, opcode/extension encodings, condition codes and PSR bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_MEM   = 2'd3
    } state_t;

    localparam logic [3:0] OP_RTYPE = 4'b0000;
    localparam logic [3:0] OP_CMP   = 4'b0011;
    localparam logic [3:0] OP_MEMJ  = 4'b0100;
    localparam logic [3:0] OP_ADDI  = 4'b0101;
    localparam logic [3:0] OP_ADDUI = 4'b0110;
    localparam logic [3:0] OP_MOVIU = 4'b0111;
    localparam logic [3:0] OP_MOVI  = 4'b1000;
    localparam logic [3:0] OP_SUBI  = 4'b1001;
    localparam logic [3:0] OP_CMPI  = 4'b1011;
    localparam logic [3:0] OP_BCOND = 4'b1100;

    localparam logic [3:0] EXT_LOAD  = 4'b0000;
    localparam logic [3:0] EXT_STORE = 4'b0100;
    localparam logic [3:0] EXT_JCOND = 4'b1100;
    localparam logic [3:0] EXT_MOVE  = 4'b1101;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_GT = 4'b0110;
    localparam logic [3:0] CC_LE = 4'b0111;
    localparam logic [3:0] CC_FS = 4'b1000;
    localparam logic [3:0] CC_FC = 4'b1001;
    localparam logic [3:0] CC_LO = 4'b1010;
    localparam logic [3:0] CC_HS = 4'b1011;
    localparam logic [3:0] CC_UC = 4'b1110;

    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam logic [1:0] SEL_IMM = 2'b00;
    localparam logic [1:0] SEL_REG = 2'b01;
    localparam logic [1:0] SEL_MDR = 2'b10;

endpackage

// File: rtl/cpu_control_fsm_if.sv
// Control bus between the sequencer (master) and the CR16 datapath (slave).
interface cpu_control_fsm_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DISP_W = 8
);
    logic [15:0]       INS;
    logic [4:0]        PSR;
    logic              MemReady;
    logic [3:0]        OpCode;
    logic [3:0]        OpExt;
    logic              RegWrite;
    logic [REG_AW-1:0] RegIn;
    logic [REG_AW-1:0] RegA;
    logic [REG_AW-1:0] RegB;
    logic [DATA_W-1:0] Immediate;
    logic [DISP_W-1:0] PCImmediate;
    logic [1:0]        SelALU;
    logic              SelMEM;
    logic              MemRW;
    logic              PCWrite;
    logic              PCIncrement;
    logic              IRWrite;
    logic              PCReset;
    logic              IRReset;
    logic              PSRReset;
    logic              PSRWrite;

    modport master (
        input  INS, PSR, MemReady,
        output OpCode, OpExt, RegWrite, RegIn, RegA, RegB, Immediate, PCImmediate,
               SelALU, SelMEM, MemRW, PCWrite, PCIncrement, IRWrite,
               PCReset, IRReset, PSRReset, PSRWrite
    );

    modport slave (
        output INS, PSR, MemReady,
        input  OpCode, OpExt, RegWrite, RegIn, RegA, RegB, Immediate, PCImmediate,
               SelALU, SelMEM, MemRW, PCWrite, PCIncrement, IRWrite,
               PCReset, IRReset, PSRReset, PSRWrite
    );
endinterface

// File: rtl/cpu_control_fsm_cond_eval.sv
// Branch/jump condition evaluation from a 4-bit condition field and the PSR flags.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [4:0] psr_i,
    output logic       taken_o
);
    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            CC_EQ:   taken_o =  psr_i[PSR_Z];
            CC_NE:   taken_o = !psr_i[PSR_Z];
            CC_CS:   taken_o =  psr_i[PSR_C];
            CC_CC:   taken_o = !psr_i[PSR_C];
            CC_GT:   taken_o =  psr_i[PSR_N];
            CC_LE:   taken_o = !psr_i[PSR_N];
            CC_FS:   taken_o =  psr_i[PSR_F];
            CC_FC:   taken_o = !psr_i[PSR_F];
            CC_LO:   taken_o =  psr_i[PSR_L];
            CC_HS:   taken_o = !psr_i[PSR_L];
            CC_UC:   taken_o = 1'b1;
            default: taken_o = 1'b0;
        endcase
    end
endmodule

// File: rtl/cpu_control_fsm.sv
// Multi-cycle Fetch/Execute/Memory sequencer for the CR16-style datapath.
// Outputs are a pure decode of state, INS, PSR and MemReady.
module cpu_control_fsm
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4,
    parameter int DISP_W = 8
) (
    input  logic               Clock,
    input  logic               Reset,
    cpu_control_fsm_if.master  bus
);
    localparam logic [DISP_W-1:0] DISP_ONE = DISP_W'(1);

    function automatic logic [DATA_W-1:0] imm_ext(input logic [3:0] op, input logic [7:0] v);
        logic [DATA_W-1:0] r;
        case (op)
            OP_ADDI, OP_SUBI, OP_CMPI: r = {{(DATA_W-8){v[7]}}, v};
            OP_ADDUI, OP_MOVI:         r = {{(DATA_W-8){1'b0}}, v};
            OP_MOVIU:                  r = DATA_W'(v) << (DATA_W-8);
            default:                   r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [DISP_W-1:0] disp_ext(input logic [7:0] d);
        logic signed [31:0] w;
        w = 32'($signed(d));
        return w[DISP_W-1:0];
    endfunction

    state_t            state_q, state_d;
    logic [3:0]        opcode, ext_hi, ext_lo;
    logic [REG_AW-1:0] reg_a, reg_b;
    logic              taken, is_alu, is_load, is_store, is_jcond, is_cmp;

    assign opcode   = bus.INS[15:12];
    assign ext_hi   = bus.INS[11:8];
    assign ext_lo   = bus.INS[7:4];
    assign reg_a    = bus.INS[REG_AW-1:0];
    assign reg_b    = bus.INS[REG_AW+3:4];
    assign is_load  = (opcode == OP_MEMJ) && (ext_hi == EXT_LOAD);
    assign is_store = (opcode == OP_MEMJ) && (ext_hi == EXT_STORE);
    assign is_jcond = (opcode == OP_MEMJ) && !is_load && !is_store && (ext_lo == EXT_JCOND);
    assign is_cmp   = (opcode == OP_CMP) || (opcode == OP_CMPI);
    assign is_alu   = (opcode == OP_RTYPE) || (opcode == OP_CMP)  || (opcode == OP_ADDI) ||
                      (opcode == OP_ADDUI) || (opcode == OP_MOVIU) || (opcode == OP_MOVI) ||
                      (opcode == OP_SUBI)  || (opcode == OP_CMPI);

    cond_eval u_cond (
        .cond_i  (ext_hi),
        .psr_i   (bus.PSR),
        .taken_o (taken)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= S_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        bus.OpCode      = '0;
        bus.OpExt       = '0;
        bus.RegWrite    = 1'b0;
        bus.RegIn       = '0;
        bus.RegA        = '0;
        bus.RegB        = '0;
        bus.Immediate   = '0;
        bus.PCImmediate = '0;
        bus.SelALU      = SEL_IMM;
        bus.SelMEM      = 1'b0;
        bus.MemRW       = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCIncrement = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PSRWrite    = 1'b0;
        // Active-low clears are released everywhere except the reset state.
        bus.PCReset     = (state_q != S_INIT);
        bus.IRReset     = (state_q != S_INIT);
        bus.PSRReset    = (state_q != S_INIT);
        case (state_q)
            S_INIT: state_d = S_FETCH;
            S_FETCH: begin
                bus.SelMEM  = 1'b1;
                bus.IRWrite = 1'b1;
                if (bus.MemReady) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (is_alu) begin
                    bus.OpCode      = opcode;
                    bus.OpExt       = ext_hi;
                    bus.RegIn       = reg_a;
                    bus.RegA        = reg_a;
                    bus.RegB        = reg_b;
                    bus.SelALU      = (opcode == OP_RTYPE || opcode == OP_CMP) ? SEL_REG : SEL_IMM;
                    bus.Immediate   = imm_ext(opcode, bus.INS[11:4]);
                    bus.RegWrite    = !is_cmp;
                    bus.PSRWrite    = 1'b1;
                    bus.PCIncrement = 1'b1;
                    bus.PCImmediate = DISP_ONE;
                end else if (is_load || is_store) begin
                    state_d = S_MEM;
                end else if (is_jcond && taken) begin
                    bus.PCWrite = 1'b1;
                    bus.RegB    = reg_a;
                end else if (opcode == OP_BCOND) begin
                    bus.PCIncrement = 1'b1;
                    bus.PCImmediate = taken ? disp_ext(bus.INS[7:0]) : DISP_ONE;
                end else begin
                    bus.PCIncrement = 1'b1;
                    bus.PCImmediate = DISP_ONE;
                end
            end
            S_MEM: begin
                bus.SelMEM = 1'b0;
                bus.RegB   = reg_b;
                if (is_load) begin
                    bus.SelALU   = SEL_MDR;
                    bus.OpCode   = OP_RTYPE;
                    bus.OpExt    = EXT_MOVE;
                    bus.RegIn    = reg_a;
                    bus.RegWrite = bus.MemReady;
                end else begin
                    bus.MemRW = 1'b1;
                    bus.RegA  = reg_a;
                end
                if (bus.MemReady) begin
                    bus.PCIncrement = 1'b1;
                    bus.PCImmediate = DISP_ONE;
                    state_d         = S_FETCH;
                end
            end
            default: state_d = S_INIT;
        endcase
    end
endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: each task walks one instruction through
// Fetch/Execute/Memory and compares the decoded control lines against hand values.
module tb_cpu_control_fsm;
    logic Clock;
    logic Reset;
    int   checks;
    int   errors;

    cpu_control_fsm_if #(.DATA_W(16), .REG_AW(4), .DISP_W(8)) bus ();

    cpu_control_fsm #(.DATA_W(16), .REG_AW(4), .DISP_W(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; bus.INS = 16'h0000; bus.PSR = 5'b0; bus.MemReady = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        checks++; if (bus.PCReset !== 1'b0) begin errors++; $display("FAIL init_pcreset got %b exp 0", bus.PCReset); end
        checks++; if (bus.IRReset !== 1'b0) begin errors++; $display("FAIL init_irreset got %b exp 0", bus.IRReset); end
        checks++; if (bus.PSRReset !== 1'b0) begin errors++; $display("FAIL init_psrreset got %b exp 0", bus.PSRReset); end
        checks++; if ({bus.IRWrite, bus.SelMEM, bus.PCIncrement} !== 3'b000) begin errors++; $display("FAIL init_enables got %b exp 000", {bus.IRWrite, bus.SelMEM, bus.PCIncrement}); end
        Reset = 1'b0;
        cycle();
        checks++; if ({bus.SelMEM, bus.IRWrite, bus.PCReset} !== 3'b111) begin errors++; $display("FAIL fetch_lines got %b exp 111", {bus.SelMEM, bus.IRWrite, bus.PCReset}); end
        checks++; if (bus.RegWrite !== 1'b0) begin errors++; $display("FAIL fetch_regwrite got %b exp 0", bus.RegWrite); end
    endtask

    task automatic test_movi();
        bus.INS = 16'h8053; bus.MemReady = 1'b1;
        cycle();
        checks++; if (bus.RegIn !== 4'h3) begin errors++; $display("FAIL movi_regin got %h exp 3", bus.RegIn); end
        checks++; if (bus.Immediate !== 16'h0005) begin errors++; $display("FAIL movi_imm got %h exp 0005", bus.Immediate); end
        checks++; if (bus.RegWrite !== 1'b1) begin errors++; $display("FAIL movi_regwrite got %b exp 1", bus.RegWrite); end
        checks++; if (bus.PCImmediate !== 8'h01) begin errors++; $display("FAIL movi_pcimm got %h exp 01", bus.PCImmediate); end
        cycle();
    endtask

    task automatic test_addi_fetch_wait();
        bus.INS = 16'h5FF2; bus.MemReady = 1'b0;
        cycle();
        checks++; if ({bus.IRWrite, bus.SelMEM, bus.PSRWrite} !== 3'b110) begin errors++; $display("FAIL fetch_wait got %b exp 110", {bus.IRWrite, bus.SelMEM, bus.PSRWrite}); end
        bus.MemReady = 1'b1;
        cycle();
        checks++; if (bus.Immediate !== 16'hFFFF) begin errors++; $display("FAIL addi_imm got %h exp FFFF", bus.Immediate); end
        checks++; if (bus.SelALU !== 2'b00) begin errors++; $display("FAIL addi_selalu got %b exp 00", bus.SelALU); end
        checks++; if (bus.PSRWrite !== 1'b1) begin errors++; $display("FAIL addi_psrwrite got %b exp 1", bus.PSRWrite); end
        cycle();
    endtask

    task automatic test_imm_variants();
        bus.INS = 16'h7AB1;
        cycle();
        checks++; if (bus.Immediate !== 16'hAB00) begin errors++; $display("FAIL moviu_imm got %h exp AB00", bus.Immediate); end
        cycle();
        bus.INS = 16'h6FF1;
        cycle();
        checks++; if (bus.Immediate !== 16'h00FF) begin errors++; $display("FAIL addui_imm got %h exp 00FF", bus.Immediate); end
        cycle();
        bus.INS = 16'hBF02;
        cycle();
        checks++; if (bus.Immediate !== 16'hFFF0) begin errors++; $display("FAIL cmpi_imm got %h exp FFF0", bus.Immediate); end
        checks++; if ({bus.RegWrite, bus.PSRWrite} !== 2'b01) begin errors++; $display("FAIL cmpi_writes got %b exp 01", {bus.RegWrite, bus.PSRWrite}); end
        cycle();
        bus.INS = 16'h3012;
        cycle();
        checks++; if ({bus.RegWrite, bus.PSRWrite, bus.SelALU} !== 4'b0101) begin errors++; $display("FAIL cmp_lines got %b exp 0101", {bus.RegWrite, bus.PSRWrite, bus.SelALU}); end
        cycle();
        bus.INS = 16'hF000;
        cycle();
        checks++; if ({bus.RegWrite, bus.PSRWrite, bus.MemRW, bus.PCWrite, bus.PCIncrement} !== 5'b00001) begin errors++; $display("FAIL nop_lines got %b exp 00001", {bus.RegWrite, bus.PSRWrite, bus.MemRW, bus.PCWrite, bus.PCIncrement}); end
        cycle();
    endtask

    task automatic test_load_wait();
        bus.INS = 16'h4021; bus.MemReady = 1'b1;
        cycle();
        checks++; if ({bus.RegWrite, bus.PCIncrement, bus.PCWrite, bus.IRWrite, bus.MemRW, bus.PSRWrite} !== 6'b0) begin errors++; $display("FAIL load_exec_enables got %b exp 000000", {bus.RegWrite, bus.PCIncrement, bus.PCWrite, bus.IRWrite, bus.MemRW, bus.PSRWrite}); end
        bus.MemReady = 1'b0;
        cycle();
        checks++; if ({bus.SelALU, bus.SelMEM, bus.RegB, bus.RegIn, bus.OpExt} !== {2'b10, 1'b0, 4'h2, 4'h1, 4'hD}) begin errors++; $display("FAIL load_mem_lines got %h exp %h", {bus.SelALU, bus.SelMEM, bus.RegB, bus.RegIn, bus.OpExt}, {2'b10, 1'b0, 4'h2, 4'h1, 4'hD}); end
        checks++; if ({bus.RegWrite, bus.PCIncrement} !== 2'b00) begin errors++; $display("FAIL load_wait1 got %b exp 00", {bus.RegWrite, bus.PCIncrement}); end
        cycle();
        checks++; if ({bus.RegWrite, bus.PCIncrement} !== 2'b00) begin errors++; $display("FAIL load_wait2 got %b exp 00", {bus.RegWrite, bus.PCIncrement}); end
        bus.MemReady = 1'b1;
        #1;
        checks++; if ({bus.RegWrite, bus.PCIncrement} !== 2'b11) begin errors++; $display("FAIL load_ready got %b exp 11", {bus.RegWrite, bus.PCIncrement}); end
        cycle();
        checks++; if ({bus.IRWrite, bus.SelMEM, bus.RegWrite} !== 3'b110) begin errors++; $display("FAIL load_return_fetch got %b exp 110", {bus.IRWrite, bus.SelMEM, bus.RegWrite}); end
    endtask

    task automatic test_branch_jump();
        bus.INS = 16'hC0FC; bus.PSR = 5'b01000;
        cycle();
        checks++; if ({bus.PCIncrement, bus.PCWrite, bus.PCImmediate} !== {2'b10, 8'hFC}) begin errors++; $display("FAIL beq_taken got %h exp %h", {bus.PCIncrement, bus.PCWrite, bus.PCImmediate}, {2'b10, 8'hFC}); end
        cycle();
        bus.PSR = 5'b00000;
        cycle();
        checks++; if ({bus.PCIncrement, bus.PCImmediate} !== {1'b1, 8'h01}) begin errors++; $display("FAIL beq_not_taken got %h exp %h", {bus.PCIncrement, bus.PCImmediate}, {1'b1, 8'h01}); end
        cycle();
        bus.INS = 16'hCA05; bus.PSR = 5'b00010;
        cycle();
        checks++; if (bus.PCImmediate !== 8'h05) begin errors++; $display("FAIL blo_taken got %h exp 05", bus.PCImmediate); end
        cycle();
        bus.INS = 16'h4EC5; bus.PSR = 5'b00000;
        cycle();
        checks++; if ({bus.PCWrite, bus.PCIncrement, bus.RegB} !== {2'b10, 4'h5}) begin errors++; $display("FAIL juc_lines got %h exp %h", {bus.PCWrite, bus.PCIncrement, bus.RegB}, {2'b10, 4'h5}); end
        cycle();
        bus.INS = 16'h41C5; bus.PSR = 5'b01000;
        cycle();
        checks++; if ({bus.PCWrite, bus.PCIncrement, bus.PCImmediate} !== {2'b01, 8'h01}) begin errors++; $display("FAIL jne_not_taken got %h exp %h", {bus.PCWrite, bus.PCIncrement, bus.PCImmediate}, {2'b01, 8'h01}); end
        cycle();
    endtask

    task automatic test_store_reset();
        bus.INS = 16'h4435; bus.MemReady = 1'b1;
        cycle();
        bus.MemReady = 1'b0;
        cycle();
        checks++; if ({bus.MemRW, bus.IRWrite, bus.SelMEM, bus.RegA, bus.RegB} !== {3'b100, 4'h5, 4'h3}) begin errors++; $display("FAIL store_mem_lines got %h exp %h", {bus.MemRW, bus.IRWrite, bus.SelMEM, bus.RegA, bus.RegB}, {3'b100, 4'h5, 4'h3}); end
        cycle();
        checks++; if ({bus.MemRW, bus.PCIncrement} !== 2'b10) begin errors++; $display("FAIL store_hold got %b exp 10", {bus.MemRW, bus.PCIncrement}); end
        #2;
        Reset = 1'b1;
        #1;
        checks++; if ({bus.MemRW, bus.PCReset, bus.IRReset} !== 3'b000) begin errors++; $display("FAIL store_reset_async got %b exp 000", {bus.MemRW, bus.PCReset, bus.IRReset}); end
        cycle();
        Reset = 1'b0; bus.MemReady = 1'b1;
        #1;
        checks++; if ({bus.PSRReset, bus.IRWrite} !== 2'b00) begin errors++; $display("FAIL post_reset_init got %b exp 00", {bus.PSRReset, bus.IRWrite}); end
        cycle();
        checks++; if ({bus.IRWrite, bus.SelMEM, bus.PSRReset, bus.MemRW} !== 4'b1110) begin errors++; $display("FAIL post_reset_fetch got %b exp 1110", {bus.IRWrite, bus.SelMEM, bus.PSRReset, bus.MemRW}); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_movi();
        test_addi_fetch_wait();
        test_imm_variants();
        test_load_wait();
        test_branch_jump();
        test_store_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
